fpu_config_loader: RTL and testbench
====================================

// Module: fpu_config_loader
// PURPOSE
//  Implements the Loader side of the FPU configuration interface.
//  On load_config_start it fetches a 6-word config record from memory-mapped space.
//  It unpacks the record into image size, source/result addresses and the 3x3 signed filter.
//  These are held stable for the FPU datapath until the next load; done marks them valid.
// PARAMETERS
//  CONFIG_BASE  32'h0000_1000  byte address of config word 0
//  WORD_STRIDE  4              byte increment between consecutive config words
// PORTS
//  clk                input   1      system clock, all state on rising edge
//  rst_n              input   1      asynchronous active-low reset
//  load_config_start  input   1      request a config fetch (sampled in IDLE/DONE only)
//  mapped_data_valid  input   1      data_mem holds the word for address_mem this cycle
//  data_mem           input   32     read data from memory-mapped space
//  mem_rd             output  1      read request; address_mem valid while high
//  address_mem        output  32     byte address of the config word being read
//  load_config_done   output  1      committed config valid (level)
//  filter[8:0]        output  9x8s   signed 3x3 kernel, index 0 = top-left, row-major
//  image_width        output  16     pixels per row
//  image_height       output  16     rows
//  start_address      output  32     source image base address
//  result_address     output  32     destination image base address
//  config_err         output  1      see CONFIGURATION
// BEHAVIOUR
//  Reset: state=IDLE, mem_rd=0, address_mem=0, done=0, config_err=0.
//  Reset: all config outputs and shadow registers =0.
//  Record layout (word i at CONFIG_BASE+i*WORD_STRIDE):
//   w0={image_height,image_width} w1=start_address w2=result_address
//   w3={f3,f2,f1,f0} w4={f7,f6,f5,f4} w5[7:0]=f8, w5[31:8] ignored
//  FSM IDLE -> FETCH -> COMMIT -> DONE:
//   IDLE/DONE: start=1 -> FETCH, idx=0, done<=0.
//   FETCH: mem_rd=1, address_mem=CONFIG_BASE+idx*WORD_STRIDE.
//   FETCH: on valid, capture data_mem into shadow[idx] and increment idx.
//   FETCH: on valid with idx=5 -> COMMIT.
//   FETCH: address_mem holds while valid=0 (unbounded wait).
//   COMMIT (1 cycle): shadow -> outputs, mem_rd=0 -> DONE, done<=1.
//   DONE: done held high, outputs stable until the next start.
//  Outputs change only in COMMIT; a partial fetch never leaks to the datapath.
//  Latency with valid tied high:
//   start sampled at edge E0; words captured E1..E6; commit at E7.
//   done is high after E7.
//  mapped_data_valid while mem_rd=0 is ignored.
//  start while in FETCH/COMMIT is ignored; no restart, no queueing.
//  start and valid in the same cycle in IDLE: valid ignored, fetch starts at w0.
//  rst_n low mid-fetch: immediate return to reset values; prior config is lost.
//  Filter bytes are two's complement, copied bit-exact; no sign extension.
//  idx is 3 bits; values 6..7 are unreachable. Any such value forces IDLE.
// CONFIGURATION
//  FPU_CONFIG_CHECK_EN defined:
//   COMMIT sets config_err=1 if width==0, height==0, or start_address==result_address.
//   COMMIT sets config_err=1 if start_address[1:0]!=0 or result_address[1:0]!=0.
//   Otherwise COMMIT sets config_err=0.
//   config_err updates only in COMMIT; done still asserts (the consumer decides).
//  FPU_CONFIG_CHECK_EN undefined: config_err tied 0, no check logic.
// TESTING
//  1 Reset: rst_n=0 -> all outputs 0, state IDLE.
//    Release, 10 idle cycles -> mem_rd=0, done=0.
//  2 Nominal load, valid tied 1, memory w0..w5 =
//    32'h01E0_0280, 32'h0001_0000, 32'h0002_0000, 32'hFF01_FF01, 32'h0108_FF01, 32'h0000_00FF.
//    -> width=640, height=480, start=0x10000, result=0x20000.
//    -> f0=1 f1=-1 f2=1 f3=-1 f4=1 f5=-1 f6=8 f7=1 f8=-1.
//    -> done high after E7; addresses seen 0x1000,0x1004,...,0x1014.
//  3 Wait states: valid=1 only every 3rd cycle -> identical outputs.
//    address_mem stable during each wait; no output changes before COMMIT.
//  4 Reload: done=1, start with a new record (width=32).
//    -> done drops the next cycle; old width held until COMMIT, then 32.
//    -> start pulses during FETCH produce no extra fetches.
//  5 Reset mid-fetch after w2 -> all outputs 0 at once.
//    Next start fetches from 0x1000.
//  6 FPU_CONFIG_CHECK_EN: w0=32'h01E0_0000 (width 0) -> config_err=1, done=1.
//    Valid record -> config_err=0. Macro undefined -> config_err=0 always.

Source files
------------

// File: rtl/fpu_config_loader.sv
// fpu_config_loader: fetches a 6-word config record and commits it atomically to the FPU datapath.
// Define FPU_CONFIG_CHECK_EN to flag zero sizes, aliased or misaligned addresses on config_err.
module fpu_config_loader #(
    parameter logic [31:0] CONFIG_BASE = 32'h0000_1000,
    parameter logic [31:0] WORD_STRIDE = 32'd4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_config_start,
    input  logic            mapped_data_valid,
    input  logic [31:0]     data_mem,
    output logic            mem_rd,
    output logic [31:0]     address_mem,
    output logic            load_config_done,
    output logic [8:0][7:0] filter,
    output logic [15:0]     image_width,
    output logic [15:0]     image_height,
    output logic [31:0]     start_address,
    output logic [31:0]     result_address,
    output logic            config_err
);
    typedef enum logic [1:0] {IDLE, FETCH, COMMIT, DONE} state_t;
    state_t state, state_nxt;
    logic [2:0] idx;
    logic [31:0] sh_size, sh_src, sh_dst, sh_f0, sh_f1;
    logic [7:0] sh_f8;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: state_nxt = load_config_start ? FETCH : state;
            FETCH:      state_nxt = idx > 3'd5 ? IDLE : (mapped_data_valid && idx == 3'd5) ? COMMIT : FETCH;
            COMMIT:     state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end
    always_comb begin
        mem_rd           = state == FETCH;
        address_mem      = mem_rd ? CONFIG_BASE + 32'(idx) * WORD_STRIDE : '0;
        load_config_done = state == DONE;
    end
    // Words land in shadow registers so a partial fetch never reaches the datapath.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            idx            <= '0;
            sh_size        <= '0;
            sh_src         <= '0;
            sh_dst         <= '0;
            sh_f0          <= '0;
            sh_f1          <= '0;
            sh_f8          <= '0;
            filter         <= '0;
            image_width    <= '0;
            image_height   <= '0;
            start_address  <= '0;
            result_address <= '0;
        end else begin
            idx <= state != FETCH ? 3'd0 : mapped_data_valid ? idx + 3'd1 : idx;
            if (state == FETCH && mapped_data_valid)
                case (idx)
                    3'd0:    sh_size <= data_mem;
                    3'd1:    sh_src  <= data_mem;
                    3'd2:    sh_dst  <= data_mem;
                    3'd3:    sh_f0   <= data_mem;
                    3'd4:    sh_f1   <= data_mem;
                    3'd5:    sh_f8   <= data_mem[7:0];
                    default: ;
                endcase
            if (state == COMMIT) begin
                image_width    <= sh_size[15:0];
                image_height   <= sh_size[31:16];
                start_address  <= sh_src;
                result_address <= sh_dst;
                filter         <= {sh_f8, sh_f1, sh_f0};
            end
        end
`ifdef FPU_CONFIG_CHECK_EN
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) config_err <= 1'b0;
        else if (state == COMMIT)
            config_err <= sh_size[15:0] == 16'd0 || sh_size[31:16] == 16'd0 || sh_src == sh_dst
                          || |sh_src[1:0] || |sh_dst[1:0];
`else
    assign config_err = 1'b0;
`endif
endmodule

// File: tb/tb_fpu_config_loader.sv
// tb_fpu_config_loader: table-driven record loads plus reset, reload and mid-fetch reset sequences.
module tb_fpu_config_loader;
    logic            clk = 0;
    logic            rst_n = 0;
    logic            load_config_start = 0;
    logic            mapped_data_valid = 0;
    logic [31:0]     data_mem;
    logic            mem_rd;
    logic [31:0]     address_mem;
    logic            load_config_done;
    logic [8:0][7:0] filter;
    logic [15:0]     image_width, image_height;
    logic [31:0]     start_address, result_address;
    logic            config_err;

    fpu_config_loader dut (
        .clk(clk), .rst_n(rst_n), .load_config_start(load_config_start),
        .mapped_data_valid(mapped_data_valid), .data_mem(data_mem), .mem_rd(mem_rd),
        .address_mem(address_mem), .load_config_done(load_config_done), .filter(filter),
        .image_width(image_width), .image_height(image_height), .start_address(start_address),
        .result_address(result_address), .config_err(config_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [0:5][31:0] w;
        logic             slow;
        logic [15:0]      ew, eh;
        logic [31:0]      es, er;
        logic [0:8][7:0]  ef;
        logic             eerr;
    } vec_t;
    vec_t vec [7];

    logic [31:0] mem [6];
    logic [2:0]  ai;
    logic        slow = 0;
    int          vcnt = 0;
    logic [31:0] addrs [$];
    logic        last_wait = 0;
    logic [31:0] last_addr = 0;
    int          errs = 0, checks = 0;

    always_comb begin
        ai = 3'((address_mem - 32'h1000) >> 2);
        data_mem = (address_mem >= 32'h1000 && address_mem < 32'h1018) ? mem[ai] : 32'hDEAD_BEEF;
    end

    always @(negedge clk) begin
        vcnt++;
        mapped_data_valid = slow ? (vcnt % 3 == 0) : 1'b1;
    end

    always @(posedge clk) begin
        if (mem_rd && mapped_data_valid) addrs.push_back(address_mem);
        last_wait = mem_rd && !mapped_data_valid;
        last_addr = address_mem;
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run(input int v, input bit pulse);
        int k;
        logic [15:0] old_w;
        bit leak, hold_bad, addr_ok, idle_ok;
        logic [8:0][7:0] exp_f;
        logic exp_err;
        for (int i = 0; i < 6; i++) mem[i] = vec[v].w[i];
        for (int i = 0; i < 9; i++) exp_f[i] = vec[v].ef[i];
`ifdef FPU_CONFIG_CHECK_EN
        exp_err = vec[v].eerr;
`else
        exp_err = 1'b0;
`endif
        slow = vec[v].slow;
        old_w = image_width;
        leak = 0;
        hold_bad = 0;
        @(negedge clk);
        addrs.delete();
        load_config_start = 1;
        k = 0;
        do begin
            @(posedge clk);
            k++;
            @(negedge clk);
            load_config_start = pulse && (k == 1 || k == 3);
            if (k == 1) chk($sformatf("v%0d done_drop", v), load_config_done, 0);
            if (!load_config_done && image_width != old_w) leak = 1;
            if (last_wait && mem_rd && address_mem != last_addr) hold_bad = 1;
        end while (!load_config_done && k < 300);
        load_config_start = 0;
        chk($sformatf("v%0d done_seen", v), load_config_done, 1);
        if (!vec[v].slow) chk($sformatf("v%0d latency", v), k, 8);
        addr_ok = addrs.size() == 6;
        for (int i = 0; i < addrs.size() && i < 6; i++)
            if (addrs[i] != 32'h1000 + 32'(4 * i)) addr_ok = 0;
        chk($sformatf("v%0d addr_seq", v), addr_ok, 1);
        chk($sformatf("v%0d width", v), image_width, vec[v].ew);
        chk($sformatf("v%0d height", v), image_height, vec[v].eh);
        chk($sformatf("v%0d start", v), start_address, vec[v].es);
        chk($sformatf("v%0d result", v), result_address, vec[v].er);
        chk($sformatf("v%0d filter", v), filter, exp_f);
        chk($sformatf("v%0d config_err", v), config_err, exp_err);
        chk($sformatf("v%0d no_leak", v), leak, 0);
        chk($sformatf("v%0d addr_hold", v), hold_bad, 0);
        idle_ok = 1;
        repeat (4) begin
            @(negedge clk);
            if (mem_rd || !load_config_done || image_width != vec[v].ew) idle_ok = 0;
        end
        chk($sformatf("v%0d idle_after", v), idle_ok, 1);
    endtask

    initial begin
        vec[0] = '{w: '{32'h01E0_0280, 32'h0001_0000, 32'h0002_0000, 32'hFF01_FF01, 32'h0108_FF01, 32'h0000_00FF},
                   slow: 0, ew: 16'd640, eh: 16'd480, es: 32'h0001_0000, er: 32'h0002_0000,
                   ef: '{8'h01, 8'hFF, 8'h01, 8'hFF, 8'h01, 8'hFF, 8'h08, 8'h01, 8'hFF}, eerr: 0};
        vec[1] = vec[0];
        vec[1].slow = 1;
        vec[2] = '{w: '{32'h0010_0020, 32'h0000_4000, 32'h0000_8000, 32'h7F80_0102, 32'hFEFD_0304, 32'hABCD_EF05},
                   slow: 0, ew: 16'd32, eh: 16'd16, es: 32'h0000_4000, er: 32'h0000_8000,
                   ef: '{8'h02, 8'h01, 8'h80, 8'h7F, 8'h04, 8'h03, 8'hFD, 8'hFE, 8'h05}, eerr: 0};
        vec[3] = '{w: '{32'h01E0_0000, 32'h0001_0000, 32'h0002_0000, 32'h0, 32'h0, 32'h0},
                   slow: 0, ew: 16'd0, eh: 16'd480, es: 32'h0001_0000, er: 32'h0002_0000,
                   ef: '0, eerr: 1};
        vec[4] = '{w: '{32'h0001_0001, 32'h0000_0100, 32'h0000_0100, 32'h8000_0001, 32'h0, 32'h0000_0080},
                   slow: 0, ew: 16'd1, eh: 16'd1, es: 32'h0000_0100, er: 32'h0000_0100,
                   ef: '{8'h01, 8'h00, 8'h00, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80}, eerr: 1};
        vec[5] = '{w: '{32'h0002_0002, 32'h0000_0102, 32'h0000_0200, 32'h0, 32'h0, 32'hFFFF_FF00},
                   slow: 1, ew: 16'd2, eh: 16'd2, es: 32'h0000_0102, er: 32'h0000_0200,
                   ef: '0, eerr: 1};
        vec[6] = vec[0];
        for (int i = 0; i < 6; i++) mem[i] = 32'h0;

        repeat (2) @(negedge clk);
        chk("reset_outputs", {mem_rd, address_mem, load_config_done, filter, image_width, image_height,
                              start_address, result_address, config_err}, 0);
        rst_n = 1;
        repeat (10) @(negedge clk);
        chk("idle_quiet", {mem_rd, load_config_done}, 0);

        for (int v = 0; v < 7; v++) run(v, v == 2);

        for (int i = 0; i < 6; i++) mem[i] = vec[2].w[i];
        slow = 0;
        @(negedge clk);
        addrs.delete();
        load_config_start = 1;
        @(negedge clk);
        load_config_start = 0;
        for (int i = 0; i < 20 && addrs.size() < 3; i++) @(negedge clk);
        chk("midfetch_reached", addrs.size() >= 3, 1);
        rst_n = 0;
        #1;
        chk("midfetch_reset", {mem_rd, address_mem, load_config_done, filter, image_width, image_height,
                               start_address, result_address, config_err}, 0);
        @(negedge clk);
        rst_n = 1;
        run(0, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
